// File: rtl/bp_be_pkg.sv
// Shared back-end types for the stride prefetch issuer: FSM state encoding and
// the processor-config selector that sets the virtual address width.
package bp_be_pkg;

    typedef enum logic [1:0] {
        e_idle  = 2'd0,
        e_train = 2'd1,
        e_issue = 2'd2
    } bp_be_pf_state_e;

    typedef enum logic [0:0] {
        e_bp_default_cfg = 1'b0
    } bp_params_e;

    function automatic int bp_vaddr_width(bp_params_e cfg);
        case (cfg)
            e_bp_default_cfg: return 39;
            default:          return 39;
        endcase
    endfunction

endpackage

// File: rtl/bsg_counter_clear_up.sv
// Up counter with synchronous clear. When clear and up arrive together, the
// clear happens first and then the count is 1.
module bsg_counter_clear_up #(
    parameter int max_val_p  = 4,
    parameter int init_val_p = 0,
    localparam int ptr_width_lp = $clog2(max_val_p + 1)
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    input  logic                    clear_i,
    input  logic                    up_i,
    output logic [ptr_width_lp-1:0] count_o
);

    always_ff @(posedge clk_i) begin
        if (reset_i)
            count_o <= ptr_width_lp'(init_val_p);
        else if (clear_i)
            count_o <= ptr_width_lp'(up_i);
        else if (up_i)
            count_o <= count_o + 1'b1;
    end

endmodule

// File: rtl/bp_be_stride_pf_issuer.sv
// Stride prefetch issuer: trains on a start/confirm pair, then issues degree_p
// prefetches. Define BP_BE_PF_PAGE_CROSS_EN to let a stream leave its page.
module bp_be_stride_pf_issuer
    import bp_be_pkg::*;
#(
    parameter bp_params_e bp_params_p     = e_bp_default_cfg,
    parameter int         stride_width_p  = 8,
    parameter int         degree_p        = 4,
    parameter int         page_offset_width_p = 12,
    localparam int        vaddr_width_p   = bp_vaddr_width(bp_params_p)
) (
    input  logic                      clk_i,
    input  logic                      reset_i,
    input  logic                      stride_v_i,
    input  logic [stride_width_p-1:0] stride_i,
    input  logic [vaddr_width_p-1:0]  pc_i,
    input  logic [vaddr_width_p-1:0]  eff_addr_i,
    input  logic                      start_discovery_i,
    input  logic                      confirm_discovery_i,
    input  logic                      flush_i,
    output logic                      pf_v_o,
    output logic [vaddr_width_p-1:0]  pf_addr_o,
    input  logic                      pf_ready_and_i,
    output logic                      busy_o
);

    localparam int page_width_lp = vaddr_width_p - page_offset_width_p;
    localparam int cnt_width_lp  = $clog2(degree_p + 1);
    localparam logic [cnt_width_lp-1:0] last_cnt_lp = cnt_width_lp'(degree_p - 1);

    bp_be_pf_state_e state_r, state_n;

    logic [stride_width_p-1:0] stride_r;
    logic [vaddr_width_p-1:0]  pc_r, base_r, next_r;
    logic [page_width_lp-1:0]  page_r;
    logic                      pf_v_r;
    logic [cnt_width_lp-1:0]   cnt;

    logic load, go, adv, hs;
    logic [vaddr_width_p-1:0] stride_ext, confirm_addr, step_addr;
    logic cross_confirm, cross_step;

    assign stride_ext   = {{(vaddr_width_p-stride_width_p){stride_r[stride_width_p-1]}}, stride_r};
    assign confirm_addr = eff_addr_i + stride_ext;
    assign step_addr    = next_r + stride_ext;
    assign hs           = pf_v_r & pf_ready_and_i;

    // A page change is measured against the page of the confirming access.
`ifdef BP_BE_PF_PAGE_CROSS_EN
    assign cross_confirm = 1'b0;
    assign cross_step    = 1'b0;
`else
    assign cross_confirm = confirm_addr[vaddr_width_p-1:page_offset_width_p]
                        != eff_addr_i[vaddr_width_p-1:page_offset_width_p];
    assign cross_step    = step_addr[vaddr_width_p-1:page_offset_width_p] != page_r;
`endif

    always_ff @(posedge clk_i) begin
        if (reset_i)
            state_r <= e_idle;
        else
            state_r <= state_n;
    end

    always_comb begin
        state_n = state_r;
        load    = 1'b0;
        go      = 1'b0;
        adv     = 1'b0;
        case (state_r)
            e_idle: begin
                if (stride_v_i & start_discovery_i & (stride_i != '0)) begin
                    state_n = e_train;
                    load    = 1'b1;
                end
            end
            e_train: begin
                if (stride_v_i & start_discovery_i) begin
                    load = 1'b1;
                end else if (stride_v_i & confirm_discovery_i) begin
                    if ((stride_i == stride_r) & ~cross_confirm) begin
                        state_n = e_issue;
                        go      = 1'b1;
                    end else begin
                        state_n = e_idle;
                    end
                end
            end
            e_issue: begin
                if (hs) begin
                    if ((cnt == last_cnt_lp) | cross_step)
                        state_n = e_idle;
                    else
                        adv = 1'b1;
                end
            end
            default: state_n = e_idle;
        endcase
        if (flush_i) begin
            state_n = e_idle;
            load    = 1'b0;
            go      = 1'b0;
            adv     = 1'b0;
        end
    end

    always_comb begin
        busy_o    = (state_r != e_idle);
        pf_v_o    = pf_v_r;
        pf_addr_o = next_r;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            stride_r <= '0;
            pc_r     <= '0;
            base_r   <= '0;
            next_r   <= '0;
            page_r   <= '0;
            pf_v_r   <= 1'b0;
        end else begin
            if (load) begin
                stride_r <= stride_i;
                pc_r     <= pc_i;
                base_r   <= eff_addr_i;
            end
            if (go) begin
                next_r <= confirm_addr;
                page_r <= eff_addr_i[vaddr_width_p-1:page_offset_width_p];
            end else if (adv) begin
                next_r <= step_addr;
            end
            pf_v_r <= (state_n == e_issue);
        end
    end

    bsg_counter_clear_up #(
        .max_val_p (degree_p),
        .init_val_p(0)
    ) issued_cnt (
        .clk_i  (clk_i),
        .reset_i(reset_i),
        .clear_i(go | flush_i),
        .up_i   (hs & ~flush_i),
        .count_o(cnt)
    );

    // Trigger context kept for future table lookups; not consumed by issue logic yet.
    logic unused_ctx;
    assign unused_ctx = ^{pc_r, base_r};

endmodule

// File: tb/tb_bp_be_stride_pf_issuer.sv
// Directed bench for the stride prefetch issuer; follows BP_BE_PF_PAGE_CROSS_EN.
module tb_bp_be_stride_pf_issuer;
    import bp_be_pkg::*;

    localparam int VW = bp_vaddr_width(e_bp_default_cfg);

    logic          clk = 1'b0;
    logic          reset_i = 1'b1;
    logic          stride_v_i = 1'b0;
    logic [7:0]    stride_i = '0;
    logic [VW-1:0] pc_i = '0;
    logic [VW-1:0] eff_addr_i = '0;
    logic          start_discovery_i = 1'b0;
    logic          confirm_discovery_i = 1'b0;
    logic          flush_i = 1'b0;
    logic          pf_v_o;
    logic [VW-1:0] pf_addr_o;
    logic          pf_ready_and_i = 1'b0;
    logic          busy_o;

    int pass_cnt = 0;
    int total_cnt = 0;

    bp_be_stride_pf_issuer dut (
        .clk_i              (clk),
        .reset_i            (reset_i),
        .stride_v_i         (stride_v_i),
        .stride_i           (stride_i),
        .pc_i               (pc_i),
        .eff_addr_i         (eff_addr_i),
        .start_discovery_i  (start_discovery_i),
        .confirm_discovery_i(confirm_discovery_i),
        .flush_i            (flush_i),
        .pf_v_o             (pf_v_o),
        .pf_addr_o          (pf_addr_o),
        .pf_ready_and_i     (pf_ready_and_i),
        .busy_o             (busy_o)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_start(input logic [7:0] s, input logic [VW-1:0] a);
        stride_v_i = 1'b1; start_discovery_i = 1'b1; stride_i = s; eff_addr_i = a; pc_i = VW'(32'h400);
        tick();
        stride_v_i = 1'b0; start_discovery_i = 1'b0;
    endtask

    task automatic drive_confirm(input logic [7:0] s, input logic [VW-1:0] a);
        stride_v_i = 1'b1; confirm_discovery_i = 1'b1; stride_i = s; eff_addr_i = a;
        tick();
        stride_v_i = 1'b0; confirm_discovery_i = 1'b0;
    endtask

    task automatic test_reset();
        reset_i = 1'b1;
        tick(); tick();
        total_cnt++;
        if ({pf_v_o, busy_o, pf_addr_o} !== {2'b00, VW'(0)})
            $display("FAIL reset_outputs: got v=%b busy=%b addr=%h required 0/0/0", pf_v_o, busy_o, pf_addr_o);
        else pass_cnt++;
        reset_i = 1'b0;
        tick();
    endtask

    task automatic test_basic_stream();
        logic [VW-1:0] exp_a [4] = '{VW'(32'h1080), VW'(32'h10C0), VW'(32'h1100), VW'(32'h1140)};
        pf_ready_and_i = 1'b1;
        drive_start(8'h40, VW'(32'h1000));
        total_cnt++;
        if (busy_o !== 1'b1 || pf_v_o !== 1'b0)
            $display("FAIL train_busy: got busy=%b v=%b required 1/0", busy_o, pf_v_o);
        else pass_cnt++;
        drive_confirm(8'h40, VW'(32'h1040));
        for (int i = 0; i < 4; i++) begin
            total_cnt++;
            if (pf_v_o !== 1'b1 || pf_addr_o !== exp_a[i])
                $display("FAIL basic_req%0d: got v=%b addr=%h required 1/%h", i, pf_v_o, pf_addr_o, exp_a[i]);
            else pass_cnt++;
            tick();
        end
        total_cnt++;
        if (pf_v_o !== 1'b0 || busy_o !== 1'b0)
            $display("FAIL basic_end: got v=%b busy=%b required 0/0", pf_v_o, busy_o);
        else pass_cnt++;
    endtask

    task automatic test_backpressure();
        int hs = 0;
        pf_ready_and_i = 1'b0;
        drive_start(8'h40, VW'(32'h1000));
        drive_confirm(8'h40, VW'(32'h1040));
        for (int i = 0; i < 3; i++) begin
            // a new training event mid-issue must not disturb the stream
            stride_v_i = (i == 1); start_discovery_i = (i == 1); stride_i = 8'h10; eff_addr_i = VW'(32'h5000);
            total_cnt++;
            if (pf_v_o !== 1'b1 || pf_addr_o !== VW'(32'h1080))
                $display("FAIL stall_hold%0d: got v=%b addr=%h required 1/1080", i, pf_v_o, pf_addr_o);
            else pass_cnt++;
            tick();
        end
        stride_v_i = 1'b0; start_discovery_i = 1'b0;
        pf_ready_and_i = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (pf_v_o & pf_ready_and_i) hs++;
            tick();
        end
        total_cnt++;
        if (hs !== 4)
            $display("FAIL stall_handshakes: got %0d required 4", hs);
        else pass_cnt++;
    endtask

    task automatic test_negative_stride();
`ifdef BP_BE_PF_PAGE_CROSS_EN
        localparam int N = 4;
`else
        localparam int N = 2;
`endif
        logic [VW-1:0] exp_a [4] = '{VW'(32'h2008), VW'(32'h2000), VW'(32'h1FF8), VW'(32'h1FF0)};
        pf_ready_and_i = 1'b1;
        drive_start(8'hF8, VW'(32'h2018));
        drive_confirm(8'hF8, VW'(32'h2010));
        for (int i = 0; i < N; i++) begin
            total_cnt++;
            if (pf_v_o !== 1'b1 || pf_addr_o !== exp_a[i])
                $display("FAIL neg_req%0d: got v=%b addr=%h required 1/%h", i, pf_v_o, pf_addr_o, exp_a[i]);
            else pass_cnt++;
            tick();
        end
        total_cnt++;
        if (pf_v_o !== 1'b0 || busy_o !== 1'b0)
            $display("FAIL neg_end: got v=%b busy=%b required 0/0", pf_v_o, busy_o);
        else pass_cnt++;
    endtask

    task automatic test_flush();
        pf_ready_and_i = 1'b1;
        drive_start(8'h40, VW'(32'h1000));
        drive_confirm(8'h40, VW'(32'h1040));
        tick();
        total_cnt++;
        if (pf_v_o !== 1'b1 || pf_addr_o !== VW'(32'h10C0))
            $display("FAIL flush_pre: got v=%b addr=%h required 1/10c0", pf_v_o, pf_addr_o);
        else pass_cnt++;
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        total_cnt++;
        if (pf_v_o !== 1'b0 || busy_o !== 1'b0)
            $display("FAIL flush_next: got v=%b busy=%b required 0/0", pf_v_o, busy_o);
        else pass_cnt++;
        tick(); tick();
        total_cnt++;
        if (pf_v_o !== 1'b0)
            $display("FAIL flush_no_third: got v=%b required 0", pf_v_o);
        else pass_cnt++;
    endtask

    task automatic test_mismatch_and_zero();
        drive_start(8'h10, VW'(32'h3000));
        drive_confirm(8'h20, VW'(32'h3010));
        total_cnt++;
        if (pf_v_o !== 1'b0 || busy_o !== 1'b0)
            $display("FAIL mismatch: got v=%b busy=%b required 0/0", pf_v_o, busy_o);
        else pass_cnt++;
        drive_start(8'h00, VW'(32'h3000));
        total_cnt++;
        if (busy_o !== 1'b0)
            $display("FAIL zero_stride: got busy=%b required 0", busy_o);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid_stream();
        pf_ready_and_i = 1'b0;
        drive_start(8'h40, VW'(32'h1000));
        drive_confirm(8'h40, VW'(32'h1040));
        total_cnt++;
        if (pf_v_o !== 1'b1)
            $display("FAIL rst_pre: got v=%b required 1", pf_v_o);
        else pass_cnt++;
        pf_ready_and_i = 1'b1;
        reset_i = 1'b1;
        tick();
        reset_i = 1'b0;
        total_cnt++;
        if ({pf_v_o, busy_o, pf_addr_o} !== {2'b00, VW'(0)})
            $display("FAIL rst_mid: got v=%b busy=%b addr=%h required 0/0/0", pf_v_o, busy_o, pf_addr_o);
        else pass_cnt++;
        drive_confirm(8'h40, VW'(32'h1040));
        tick();
        total_cnt++;
        if (pf_v_o !== 1'b0 || busy_o !== 1'b0)
            $display("FAIL rst_confirm_only: got v=%b busy=%b required 0/0", pf_v_o, busy_o);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_basic_stream();
        test_backpressure();
        test_negative_stride();
        test_flush();
        test_mismatch_and_zero();
        test_reset_mid_stream();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
